mem_sram_controller: RTL

Responder side of the MEM-stage data-memory interface. It accepts one 32-bit read or write request at a time from the MEM stage and performs it as two 16-bit accesses on an external SRAM. While the access is in progress it holds `ready` low so the pipeline freezes. When the access completes it presents the read word to the MEM-stage output register.

---
 rtl/mem_sram_controller_if.sv | 20 ++
 rtl/mem_sram_controller.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_sram_controller_if.sv
// MEM-stage data-memory request bus: one 32-bit read or write at a time,
// with a ready signal that freezes the pipeline while an access is in flight.
interface mem_sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mem_sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM accesses
// (low half first), holding every half for ACCESS_CYCLES clock cycles.
module mem_sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_sram_controller_if.slave  mem,
  output logic [17:0]           sram_addr,
  output logic                  sram_we_n,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_write_q, is_write_d;

  logic [16:0] word_idx;
  logic        last_cnt;
  logic        high_half;

  // Modulo-2^32 offset from the SRAM base; bits above the SRAM range are dropped.
  assign word_idx  = 17'((addr_q - BASE_ADDR) >> 2);
  assign last_cnt  = (cnt_q == LAST_CNT);
  assign high_half = (state_q == HIGH);

  assign mem.read_data = rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    is_write_d  = is_write_q;
    mem.ready   = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;

    case (state_q)
      IDLE: begin
        mem.ready = !mem.rd_en && !mem.wr_en;
        if (mem.rd_en || mem.wr_en) begin
          addr_d     = mem.address;
          wdata_d    = mem.write_data;
          is_write_d = mem.wr_en;
          cnt_d      = '0;
          state_d    = LOW;
        end
      end

      LOW, HIGH: begin
        sram_addr = {word_idx, high_half};
        if (is_write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = high_half ? wdata_q[31:16] : wdata_q[15:0];
        end else if (last_cnt) begin
          // Read data is taken on the final cycle of the half so the SRAM has
          // had the full access window to settle.
          if (high_half) rdata_d[31:16] = sram_dq_in;
          else           rdata_d[15:0]  = sram_dq_in;
        end
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = high_half ? DONE : HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        mem.ready = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
    end
  end

endmodule
